// File: rtl/crypto_accel_scheduler.sv
// crypto_accel_scheduler: round-robin job scheduler for one shared accelerator pipeline.
// Each job runs a zero-operand FLUSH, then a held-operand RUN, then captures the result.
// Optional feature macro: SCHED_PERF_CNT_EN (adds perf_jobs/perf_busy counters).
module crypto_accel_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned FLUSH_CYC = 9,
  parameter int unsigned RUN_CYC   = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*32-1:0]      req_a,
  input  logic [NUM_REQ*32-1:0]      req_b,
  input  logic [NUM_REQ*32-1:0]      req_c,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [63:0]                rsp_data,
  output logic                       acc_en,
  output logic [31:0]                acc_a,
  output logic [31:0]                acc_b,
  output logic [31:0]                acc_c,
  input  logic [63:0]                acc_data,
`ifdef SCHED_PERF_CNT_EN
  output logic                       busy,
  output logic [31:0]                perf_jobs,
  output logic [31:0]                perf_busy
`else
  output logic                       busy
`endif
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned MAXC = (FLUSH_CYC > RUN_CYC) ? FLUSH_CYC : RUN_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, FLUSH, RUN, CAPT, RESP} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [IDW-1:0]     rr, rr_d;
  logic [IDW-1:0]     id, id_d;
  logic [31:0]        op_a, op_a_d, op_b, op_b_d, op_c, op_c_d;
  logic [NUM_REQ-1:0] req_ready_d;
  logic               rsp_valid_d, acc_en_d, busy_d;
  logic [IDW-1:0]     rsp_id_d;
  logic [63:0]        rsp_data_d;
  logic [31:0]        acc_a_d, acc_b_d, acc_c_d;
  logic               found;
  logic [IDW-1:0]     gnt;
  logic [31:0]        a_arr [NUM_REQ];
  logic [31:0]        b_arr [NUM_REQ];
  logic [31:0]        c_arr [NUM_REQ];

  // Unpack per-requester operand slices
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_arr[g] = req_a[g*32 +: 32];
    assign b_arr[g] = req_b[g*32 +: 32];
    assign c_arr[g] = req_c[g*32 +: 32];
  end

  // Round-robin pick: first valid index at or after rr, wrapping
  always_comb begin
    int unsigned k;
    found = 1'b0;
    gnt   = '0;
    k     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(rr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req_valid[IDW'(k)]) begin
        found = 1'b1;
        gnt   = IDW'(k);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from the next state
  always_comb begin
    state_d     = state;
    cnt_d       = cnt + CW'(1);
    rr_d        = rr;
    id_d        = id;
    op_a_d      = op_a;
    op_b_d      = op_b;
    op_c_d      = op_c;
    req_ready_d = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
    acc_en_d    = 1'b0;
    acc_a_d     = '0;
    acc_b_d     = '0;
    acc_c_d     = '0;
    busy_d      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready_d[gnt] = 1'b1;
          op_a_d  = a_arr[gnt];
          op_b_d  = b_arr[gnt];
          op_c_d  = c_arr[gnt];
          id_d    = gnt;
          rr_d    = (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);
          state_d = FLUSH;
        end
      end
      FLUSH: if (cnt == CW'(FLUSH_CYC - 1)) state_d = RUN;
      RUN:   if (cnt == CW'(RUN_CYC - 1))   state_d = CAPT;
      CAPT: begin
        rsp_data_d = acc_data;
        rsp_id_d   = id;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
        else                        rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state) cnt_d = '0;
    acc_en_d = (state_d == FLUSH) || (state_d == RUN);
    if (state_d == RUN) begin
      acc_a_d = op_a_d;
      acc_b_d = op_b_d;
      acc_c_d = op_c_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State, latched job and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rr        <= '0;
      id        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      acc_en    <= 1'b0;
      acc_a     <= '0;
      acc_b     <= '0;
      acc_c     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rr        <= rr_d;
      id        <= id_d;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
      op_c      <= op_c_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_data  <= rsp_data_d;
      acc_en    <= acc_en_d;
      acc_a     <= acc_a_d;
      acc_b     <= acc_b_d;
      acc_c     <= acc_c_d;
      busy      <= busy_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Completed-job and busy-cycle counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready) perf_jobs <= perf_jobs + 32'(1);
      if (busy)                   perf_busy <= perf_busy + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_crypto_accel_scheduler.sv
// Directed bench for crypto_accel_scheduler with a small accelerator stand-in.
// Stand-in: when en, shifts a*b+c into a 6-deep window; data_out is the window sum.
module tb_crypto_accel_scheduler;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*32-1:0] req_a, req_b, req_c;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [63:0]   rsp_data;
  logic          acc_en;
  logic [31:0]   acc_a, acc_b, acc_c;
  logic [63:0]   acc_data;
  logic          busy;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]   perf_jobs, perf_busy;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  crypto_accel_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .acc_en(acc_en), .acc_a(acc_a), .acc_b(acc_b), .acc_c(acc_c),
    .acc_data(acc_data),
`ifdef SCHED_PERF_CNT_EN
    .perf_jobs(perf_jobs), .perf_busy(perf_busy),
`endif
    .busy(busy)
  );

  logic [63:0] win [6];

  always @(posedge clk) begin
    if (acc_en) begin
      win[0] <= 64'(acc_a) * 64'(acc_b) + 64'(acc_c);
      for (int i = 1; i < 6; i++) win[i] <= win[i-1];
    end
  end

  assign acc_data = win[0] + win[1] + win[2] + win[3] + win[4] + win[5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for a grant; g stays 0 if none arrives within the budget
  task automatic wait_grant(output logic [N-1:0] g, output int n);
    g = '0;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (req_ready != '0) begin
        g = req_ready;
        n = i;
        break;
      end
    end
  endtask

  // Counts cycles until rsp_valid; lat stays -1 on timeout
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // One job with rsp_ready held high; operands are scrambled after the grant
  task automatic job(input int r, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [N-1:0] exp_g,
                     input logic [63:0] exp_d, input string tag);
    logic [N-1:0] g;
    int n, lat;
    rsp_ready = 1'b1;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_c[r*32 +: 32] = c;
    req_valid[r] = 1'b1;
    wait_grant(g, n);
    chk({tag, "_grant"}, 64'(g), 64'(exp_g));
    req_valid[r] = 1'b0;
    req_a[r*32 +: 32] = 32'hDEAD_BEEF;
    req_b[r*32 +: 32] = 32'h1234_5678;
    req_c[r*32 +: 32] = 32'h0BAD_F00D;
    wait_rsp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd20);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_id"}, 64'(rsp_id), 64'(r));
    tick();
    chk({tag, "_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [N-1:0] g;
    int n, lat, hits;
    for (int i = 0; i < 6; i++) win[i] = '0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    rsp_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_acc_en", 64'(acc_en), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);

    // Basic job with cycle-accurate checks
    req_c[31:0] = 32'd1;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    chk("t1_grant", 64'(req_ready), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_flush_en", 64'(acc_en), 64'd1);
    chk("t1_flush_c", 64'(acc_c), 64'd0);
    req_valid = '0;
    tick();
    chk("t1_pulse", 64'(req_ready), 64'd0);
    repeat (8) tick();
    chk("t1_run_en", 64'(acc_en), 64'd1);
    chk("t1_run_c", 64'(acc_c), 64'd1);
    repeat (9) tick();
    chk("t1_capt_en", 64'(acc_en), 64'd0);
    tick();
    chk("t1_pre_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_data", rsp_data, 64'h6);
    chk("t1_id", 64'(rsp_id), 64'd0);
    tick();
    chk("t1_drop", 64'(rsp_valid), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // Flush isolation: large job followed by c=1 job
    job(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 4'b0100, 64'hFFFF_FFF4_0000_0030, "t2a");
    job(1, 32'd0, 32'd0, 32'd1, 4'b0010, 64'h6, "t2b");

    // All requesters held: round-robin order 0,1,2,3,0
    do_reset();
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) req_c[i*32 +: 32] = 32'(i + 1);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, n);
      chk("t3_grant", 64'(g), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("t3_gap", 64'(n), 64'd2);
      if (k == 4) req_valid = '0;
      wait_rsp(lat);
      chk("t3_lat", 64'(lat), 64'd20);
      chk("t3_data", rsp_data, 64'(6 * ((k % 4) + 1)));
      chk("t3_id", 64'(rsp_id), 64'(k % 4));
    end
    tick();

    // Backpressure in RESP with another request pending
    rsp_ready = 1'b0;
    req_c[32 +: 32] = 32'd2;
    req_valid = 4'b0010;
    wait_grant(g, n);
    chk("t4_grant", 64'(g), 64'b0010);
    req_c[31:0] = 32'd1;
    req_valid = 4'b0001;
    wait_rsp(lat);
    chk("t4_lat", 64'(lat), 64'd20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_data", rsp_data, 64'hC);
      chk("t4_hold_id", 64'(rsp_id), 64'd1);
      chk("t4_no_grant", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_release_valid", 64'(rsp_valid), 64'd0);
    chk("t4_release_busy", 64'(busy), 64'd0);
    tick();
    chk("t4_next_grant", 64'(req_ready), 64'b0001);
    req_valid = '0;
    wait_rsp(lat);
    chk("t4_next_data", rsp_data, 64'h6);
    chk("t4_next_id", 64'(rsp_id), 64'd0);
    tick();

    // Reset during RUN aborts the job
    req_a[31:0] = 32'd3;
    req_b[31:0] = 32'd5;
    req_c[31:0] = 32'd0;
    req_valid = 4'b0001;
    wait_grant(g, n);
    chk("t5_grant", 64'(g), 64'b0001);
    req_valid = '0;
    repeat (12) tick();
    chk("t5_run_a", 64'(acc_a), 64'd3);
    rst_n = 1'b0;
    tick();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_acc_en", 64'(acc_en), 64'd0);
    chk("t5_acc_a", 64'(acc_a), 64'd0);
    chk("t5_acc_b", 64'(acc_b), 64'd0);
    chk("t5_rsp_data", rsp_data, 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid || busy) hits++;
    end
    chk("t5_no_rsp", 64'(hits), 64'd0);
    job(0, 32'd0, 32'd0, 32'd1, 4'b0001, 64'h6, "t5_after");

`ifdef SCHED_PERF_CNT_EN
    // Performance counters over three unthrottled jobs
    do_reset();
    chk("perf_rst_jobs", 64'(perf_jobs), 64'd0);
    job(0, 32'd0, 32'd0, 32'd1, 4'b0001, 64'h6, "p1");
    job(1, 32'd0, 32'd0, 32'd1, 4'b0010, 64'h6, "p2");
    job(2, 32'd0, 32'd0, 32'd1, 4'b0100, 64'h6, "p3");
    chk("perf_jobs", 64'(perf_jobs), 64'd3);
    chk("perf_busy", 64'(perf_busy), 64'd63);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
